// File: rtl/spdif_frame_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : spdif_frame_scheduler
//  Purpose  : Buffers I2S stereo pairs in a small FIFO and presents them to
//             the S/PDIF biphase encoder as left/right subframes. It selects
//             the preamble class (B/M/W) and tracks the 192-frame block. It
//             also inserts the V/U/C/P bits and substitutes flagged silence
//             when the FIFO runs dry.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    FIFO_DEPTH  stereo-pair FIFO entries (power of two, >= 2)
//    CS_WORD     channel-status bits 0..31, bit i sent in frame i
//  Optional feature macro
//    SPDIF_SCHED_CS_EN  defined: C bit is taken from CS_WORD for frames 0..31
//                       undefined: C bit is always 0 and CS_WORD is unused
//  Ports
//    clk         single clock shared with the encoder
//    rst         synchronous active-high reset
//    data_left   left 24-bit sample, MSB aligned
//    data_right  right 24-bit sample
//    pair_stb    one-cycle strobe pushing {data_left, data_right}
//    sub_ready   encoder accepts the presented subframe this cycle
//    sub_valid   subframe presented
//    sub_data    [23:0] audio, [24] V, [25] U, [26] C, [27] P
//    sub_pre     preamble select: 0=B, 1=M, 2=W
//    frame_idx   current frame within the block, 0..191
//    underrun    one-cycle pulse while silence is being loaded
//    overflow    sticky flag, set when a pushed pair is dropped
// ============================================================================
module spdif_frame_scheduler #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] CS_WORD    = 32'h0000_0004
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] data_left,
    input  logic [23:0] data_right,
    input  logic        pair_stb,
    input  logic        sub_ready,
    output logic        sub_valid,
    output logic [27:0] sub_data,
    output logic [1:0]  sub_pre,
    output logic [7:0]  frame_idx,
    output logic        underrun,
    output logic        overflow
);

    localparam int         AW          = $clog2(FIFO_DEPTH);
    localparam logic [1:0] C_PRE_B     = 2'd0;
    localparam logic [1:0] C_PRE_M     = 2'd1;
    localparam logic [1:0] C_PRE_W     = 2'd2;
    localparam logic [7:0] C_LAST_FRAME = 8'd191;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_LEFT  = 2'd2,
        S_RIGHT = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    // FIFO storage; pointers carry one extra wrap bit
    logic [47:0] r_mem [FIFO_DEPTH];
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    logic [AW:0] w_wptr_nxt;
    logic [AW:0] w_rptr_nxt;
    logic        w_empty;
    logic        w_full;
    logic        w_push_ok;
    logic        w_drop;
    logic [47:0] w_head;

    // Pair register: right half and V flag are held for the second subframe
    logic [23:0] r_right_hold;
    logic        r_v_hold;

    logic        r_sub_valid;
    logic [27:0] r_sub_data;
    logic [1:0]  r_sub_pre;
    logic [7:0]  r_frame_idx;
    logic        r_underrun;
    logic        r_overflow;

    logic        w_hs;
    logic        w_pop;
    logic        w_ld_left;
    logic        w_ld_right;
    logic        w_adv;
    logic        w_c_bit;
    logic [23:0] w_load_l;
    logic [23:0] w_load_r;
    logic        w_load_v;
    logic [26:0] w_left_body;
    logic [26:0] w_right_body;

    // ------------------------------------------------------------------
    // FIFO status
    // ------------------------------------------------------------------
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
    assign w_head  = r_mem[r_rptr[AW-1:0]];

    // A pop in the same cycle frees a slot, so a push into a full FIFO
    // is still accepted when LOAD is draining it.
    assign w_push_ok  = pair_stb && (!w_full || w_pop);
    assign w_drop     = pair_stb && w_full && !w_pop;
    assign w_wptr_nxt = w_push_ok ? (r_wptr + 1'b1) : r_wptr;
    assign w_rptr_nxt = w_pop     ? (r_rptr + 1'b1) : r_rptr;

    // ------------------------------------------------------------------
    // Channel-status bit for the current frame
    // ------------------------------------------------------------------
`ifdef SPDIF_SCHED_CS_EN
    assign w_c_bit = (r_frame_idx < 8'd32) ? CS_WORD[r_frame_idx[4:0]] : 1'b0;
`else
    // CS_WORD stays referenced so the parameter remains part of the netlist
    // interface, but it never reaches the output.
    assign w_c_bit = CS_WORD[0] & 1'b0;
`endif

    // ------------------------------------------------------------------
    // Subframe assembly (U is always 0; P gives even parity over [27:0])
    // ------------------------------------------------------------------
    assign w_load_l     = w_empty ? 24'd0 : w_head[47:24];
    assign w_load_r     = w_empty ? 24'd0 : w_head[23:0];
    assign w_load_v     = w_empty;
    assign w_left_body  = {w_c_bit, 1'b0, w_load_v, w_load_l};
    assign w_right_body = {w_c_bit, 1'b0, r_v_hold, r_right_hold};

    assign w_hs = r_sub_valid && sub_ready;

    // ------------------------------------------------------------------
    // FSM next-state and control
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_ld_left   = 1'b0;
        w_ld_right  = 1'b0;
        w_adv       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_pop       = !w_empty;
                w_ld_left   = 1'b1;
                w_state_nxt = S_LEFT;
            end
            S_LEFT: begin
                if (w_hs) begin
                    w_ld_right  = 1'b1;
                    w_state_nxt = S_RIGHT;
                end
            end
            S_RIGHT: begin
                if (w_hs) begin
                    w_adv       = 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, pointers and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_right_hold <= 24'd0;
            r_v_hold     <= 1'b0;
            r_sub_valid  <= 1'b0;
            r_sub_data   <= 28'd0;
            r_sub_pre    <= C_PRE_B;
            r_frame_idx  <= 8'd0;
            r_underrun   <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wptr      <= w_wptr_nxt;
            r_rptr      <= w_rptr_nxt;
            r_sub_valid <= (w_state_nxt == S_LEFT) || (w_state_nxt == S_RIGHT);

            if (w_drop) begin
                r_overflow <= 1'b1;
            end

            // Underrun is registered one cycle early: it is raised for the
            // LOAD cycle exactly when the FIFO will be empty during it.
            r_underrun <= (w_state_nxt == S_LOAD) && (w_wptr_nxt == w_rptr_nxt);

            if (w_ld_left) begin
                r_sub_data   <= {^w_left_body, w_left_body};
                r_sub_pre    <= (r_frame_idx == 8'd0) ? C_PRE_B : C_PRE_M;
                r_right_hold <= w_load_r;
                r_v_hold     <= w_load_v;
            end

            if (w_ld_right) begin
                r_sub_data <= {^w_right_body, w_right_body};
                r_sub_pre  <= C_PRE_W;
            end

            if (w_adv) begin
                r_frame_idx <= (r_frame_idx == C_LAST_FRAME) ? 8'd0 : (r_frame_idx + 8'd1);
            end
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr[AW-1:0]] <= {data_left, data_right};
        end
    end

    assign sub_valid = r_sub_valid;
    assign sub_data  = r_sub_data;
    assign sub_pre   = r_sub_pre;
    assign frame_idx = r_frame_idx;
    assign underrun  = r_underrun;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire
